// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Fixed 34-cycle occupancy: capture, 32 CALC iterations, one FIN cycle, then a one-cycle done pulse.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pipe_flush,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_rdata,
  input  logic [31:0] rs2_rdata,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2:0]  op_q;
  logic [31:0] a_mag_q, b_mag_q;
  logic        a_neg_q, b_neg_q;
  logic        div_zero_q, div_ovf_q;
  logic [63:0] acc_q;
  logic [31:0] rem_q;
  logic [4:0]  cnt_q;

  logic        accept;
  logic        a_signed, b_signed, a_neg_in, b_neg_in;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] rem_next;
  logic [63:0] prod;
  logic [31:0] quot_s, rem_s, a_orig;
  logic [31:0] fin_result;

  assign accept = start & (state_q == IDLE) & ~done & ~pipe_flush;
  assign busy   = (state_q != IDLE);
  assign stall  = accept | busy;

  // MULH/DIV/REM are fully signed, MULHSU signs only A; MUL low bits do not depend on signedness.
  assign a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
  assign b_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01);
  assign a_neg_in = a_signed & rs1_rdata[31];
  assign b_neg_in = b_signed & rs2_rdata[31];

  // Shift-add: add A into the top half when the current B bit is set, then shift right.
  assign mul_sum   = {1'b0, acc_q[63:32]} + (b_mag_q[cnt_q] ? {1'b0, a_mag_q} : 33'd0);
  // Restoring division: bring in the next dividend bit (MSB first) and trial-subtract.
  assign div_shift = {rem_q, a_mag_q[~cnt_q]};
  assign div_ge    = (div_shift >= {1'b0, b_mag_q});
  assign rem_next  = div_ge ? (div_shift[31:0] - b_mag_q) : div_shift[31:0];

  assign prod   = (a_neg_q ^ b_neg_q) ? (64'd0 - acc_q) : acc_q;
  assign quot_s = (a_neg_q ^ b_neg_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
  assign rem_s  = a_neg_q ? (32'd0 - rem_q) : rem_q;
  assign a_orig = a_neg_q ? (32'd0 - a_mag_q) : a_mag_q;

  always_comb begin
    fin_result = 32'd0;
    case (op_q)
      3'b000:                 fin_result = prod[31:0];
      3'b001, 3'b010, 3'b011: fin_result = prod[63:32];
      3'b100: fin_result = div_zero_q ? 32'hFFFF_FFFF : (div_ovf_q ? 32'h8000_0000 : quot_s);
      3'b101: fin_result = div_zero_q ? 32'hFFFF_FFFF : acc_q[31:0];
      3'b110: fin_result = div_zero_q ? a_orig : (div_ovf_q ? 32'd0 : rem_s);
      3'b111: fin_result = div_zero_q ? a_orig : rem_q;
      default: fin_result = 32'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (pipe_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = CALC;
        CALC:    if (cnt_q == 5'd31) state_d = FIN;
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= 3'd0;
      a_mag_q    <= 32'd0;
      b_mag_q    <= 32'd0;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
      div_ovf_q  <= 1'b0;
      acc_q      <= 64'd0;
      rem_q      <= 32'd0;
      cnt_q      <= 5'd0;
      done       <= 1'b0;
      result     <= 32'd0;
    end else begin
      done <= 1'b0;
      if (!pipe_flush) begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              op_q       <= funct3;
              a_mag_q    <= a_neg_in ? (32'd0 - rs1_rdata) : rs1_rdata;
              b_mag_q    <= b_neg_in ? (32'd0 - rs2_rdata) : rs2_rdata;
              a_neg_q    <= a_neg_in;
              b_neg_q    <= b_neg_in;
              div_zero_q <= (rs2_rdata == 32'd0);
              div_ovf_q  <= funct3[2] & ~funct3[0] &
                            (rs1_rdata == 32'h8000_0000) & (rs2_rdata == 32'hFFFF_FFFF);
              acc_q      <= 64'd0;
              rem_q      <= 32'd0;
              cnt_q      <= 5'd0;
            end
          end
          CALC: begin
            cnt_q <= cnt_q + 5'd1;
            if (op_q[2]) begin
              rem_q <= rem_next;
              acc_q <= {acc_q[62:0], div_ge};
            end else begin
              acc_q <= {mul_sum, acc_q[31:1]};
            end
          end
          FIN: begin
            result <= fin_result;
            done   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed spec cases, flush, back-to-back, async reset,
// and randomized operations checked against a wide-integer arithmetic reference.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        pipe_flush;
  logic [2:0]  funct3;
  logic [31:0] rs1_rdata, rs2_rdata;
  logic        stall, busy, done;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_exp = 32'd0;

  ex_muldiv dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pipe_flush (pipe_flush),
    .funct3     (funct3),
    .rs1_rdata  (rs1_rdata),
    .rs2_rdata  (rs2_rdata),
    .stall      (stall),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // RV32M semantics from 64-bit integer arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    p  = 64'd0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // One operation from IDLE; cycle 0 is the cycle start is sampled. Operands are scrambled
  // after cycle 0 so a late or repeated capture shows up in the result.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp, got;
    int done_cyc, stall_err, busy_err, done_err;
    exp = ref_op(f3, a, b);
    got = 32'd0;
    done_cyc = -1; stall_err = 0; busy_err = 0; done_err = 0;
    @(posedge clk); #1;
    start = 1'b1; funct3 = f3; rs1_rdata = a; rs2_rdata = b;
    for (int k = 0; k <= 35; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        start = 1'b0; funct3 = 3'($urandom); rs1_rdata = $urandom; rs2_rdata = $urandom;
      end
      @(negedge clk);
      if (stall !== (k <= 33)) stall_err++;
      if (busy !== (k >= 1 && k <= 33)) busy_err++;
      if (done !== (k == 34)) done_err++;
      if (done === 1'b1 && done_cyc < 0) begin done_cyc = k; got = result; end
    end
    check({tag, "_result"}, got, exp);
    check({tag, "_done_cycle"}, done_cyc, 34);
    check({tag, "_stall_pattern_errs"}, stall_err, 0);
    check({tag, "_busy_pattern_errs"}, busy_err, 0);
    check({tag, "_done_pattern_errs"}, done_err, 0);
    last_exp = exp;
  endtask

  initial begin
    int done_cnt, done_cyc;
    logic [2:0] rf3;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; pipe_flush = 1'b0;
    funct3 = 3'd0; rs1_rdata = 32'd0; rs2_rdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_result", result, 32'd0);
    check("reset_stall", stall, 1'b0);
    rst = 1'b0;

    run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD);
    run_op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    run_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2);
    run_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2);
    run_op("divu",   3'd5, 32'hFFFF_FFF9,  32'd2);
    run_op("divu_z", 3'd5, 32'd5,          32'd0);
    run_op("rem_z",  3'd6, 32'd5,          32'd0);
    run_op("div_ov", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF);
    run_op("rem_ov", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF);

    // Flush in cycle 10 of a DIV.
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'd4; rs1_rdata = 32'd1000; rs2_rdata = 32'd3;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      pipe_flush = (k == 10);
    end
    @(negedge clk);
    check("flush_busy_c11", busy, 1'b0);
    check("flush_stall_c11", stall, 1'b0);
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    check("flush_no_done", done_cnt, 0);
    check("flush_result_kept", result, last_exp);
    run_op("mulhu_after_flush", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // start held high through done; the op in the done cycle must not restart.
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'd5; rs1_rdata = 32'd100; rs2_rdata = 32'd7;
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk); #1;
      if (k == 34) begin funct3 = 3'd7; rs1_rdata = 32'd100; rs2_rdata = 32'd7; end
    end
    @(negedge clk);
    check("b2b_done_c34", done, 1'b1);
    check("b2b_result1", result, 32'd14);
    check("b2b_stall_c34", stall, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_busy_c35", busy, 1'b0);
    check("b2b_stall_c35", stall, 1'b1);
    done_cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      if (done === 1'b1 && done_cyc < 0) begin
        done_cyc = k;
        check("b2b_result2", result, 32'd2);
      end
    end
    check("b2b_done_cycle2", done_cyc, 34);

    // Asynchronous reset in cycle 20 of an operation.
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'd4; rs1_rdata = 32'hFFFF_0000; rs2_rdata = 32'd9;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_result", result, 32'd0);
    check("arst_stall", stall, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    check("arst_no_done", done_cnt, 0);

    for (int i = 0; i < 30; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra = pick_operand();
      rb = pick_operand();
      run_op($sformatf("rand%0d_f%0d", i, rf3), rf3, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the execute stage. It produces the result that the execute stage registers into `ex_mb__alu_y` for the mem_branch stage. While an operation is in flight it stalls the front of the pipeline. Every operation has a fixed latency, so hazard and counter logic stays deterministic.

## Interface
Parameters:
- None. Width is fixed at 32 bits and the iteration count at 32.

Ports:
- `clk`  in  1  — pipeline clock; all state changes on the rising edge.
- `rst`  in  1  — asynchronous reset, active-high.
- `start`  in  1  — an M-extension instruction is in EX (decoded opcode OP, funct7 = 0000001).
- `pipe_flush`  in  1  — pipeline flush from a branch or trap; aborts any operation.
- `funct3`  in  3  — operation select:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `rs1_rdata`  in  32  — operand A.
- `rs2_rdata`  in  32  — operand B.
- `stall`  out  1  — combinational: `(start & state==IDLE & ~done & ~pipe_flush) | busy`. Holds IF/ID/EX.
- `busy`  out  1  — registered: `state != IDLE`.
- `done`  out  1  — registered, single-cycle pulse: `result` is valid.
- `result`  out  32  — registered; holds its value until the next `done`.

## Operation
- State machine: IDLE → CALC → FIN → IDLE.
- **IDLE:** when `start & ~done & ~pipe_flush`:
  - Capture `funct3`.
  - Capture operand magnitudes (two's-complement absolute value for signed operands; MULHSU treats only A as signed).
  - Capture result sign flags and the special-case flags.
  - Clear the 64-bit accumulator and the 5-bit counter, then go to CALC.
- **CALC:** 32 cycles; the counter runs 0..31; leave for FIN when the counter is 31.
  - Multiply: shift-add on the unsigned magnitudes, one bit of B per cycle, producing a 64-bit product.
  - Divide: restoring, one quotient bit per cycle, with a 33-bit partial remainder.
- **FIN:** one cycle. The result is computed and registered with `done`=1 at the end of FIN; return to IDLE.
  - Multiply:
    - Negate the 64-bit product if the operand signs differ (MULH, MULHSU).
    - MUL returns bits [31:0]; the others return bits [63:32].
  - Divide:
    - The quotient is negated if the signs differ.
    - The remainder takes the sign of the dividend.
  - Divide by zero (B = 0): quotient = 0xFFFFFFFF, remainder = A. Applies to both signed and unsigned ops.
  - Signed overflow (A = 0x80000000, B = 0xFFFFFFFF, DIV/REM only): quotient = 0x80000000, remainder = 0.
  - The special cases are detected at capture and override the datapath in FIN. Latency is unchanged.
- `start` is ignored in the cycle `done` is high. In that cycle the stalled instruction leaves EX with `result`, so it is never restarted.
- `pipe_flush` has priority over everything else:
  - Any state goes to IDLE on the next edge.
  - No `done` pulse is produced for the aborted operation.
  - `result` is unchanged.
  - A `start` in the same cycle as `pipe_flush` is ignored.
- Back-to-back operations: a new `start` is accepted in the cycle after `done`.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, counter 0, accumulator 0.
- Reset asserted mid-operation returns to IDLE immediately (asynchronous). No `done` follows.
- Latency, counting from cycle 0 as the cycle where `start` is sampled in IDLE:
  - Cycles 1–32: CALC.
  - Cycle 33: FIN.
  - Cycle 34: `done`=1 and `result` valid.
- `busy` is high in cycles 1–33.
- `stall` is high in cycles 0–33 and low in cycle 34. The EX→MB register captures `result` at the end of cycle 34.
- Occupancy is 34 stall cycles per operation, independent of operand values and of the special cases.
- All arithmetic is modulo 2^32 on the outputs; the internal product is exact at 64 bits.

## Test plan
- **MUL/MULH/MULHSU:** each op is issued separately from IDLE.
  - MUL A=7, B=0xFFFFFFFD → `result`=0xFFFFFFEB, `done` in cycle 34, `stall` high for exactly cycles 0–33.
  - MULH A=B=0x80000000 → 0x40000000.
  - MULHSU A=B=0xFFFFFFFF → 0xFFFFFFFF.
- **Signed divide:**
  - DIV A=0xFFFFFFF9 (−7), B=2 → 0xFFFFFFFD.
  - REM with the same operands → 0xFFFFFFFF.
  - DIVU with the same operands → 0x7FFFFFFC.
- **Special cases:**
  - DIVU A=5, B=0 → 0xFFFFFFFF.
  - REM A=5, B=0 → 5.
  - DIV A=0x80000000, B=0xFFFFFFFF → 0x80000000.
  - REM with those same operands → 0.
  - Each completes in cycle 34.
- **Flush:** `pipe_flush` in cycle 10 of a DIV.
  - Required: `busy`=0 in cycle 11, no `done` pulse, `result` keeps its previous value.
  - Next: `start` with MULHU A=B=0xFFFFFFFF → `result`=0xFFFFFFFE 34 cycles later.
- **Back-to-back and reset:**
  - `start` held high through `done`: no restart in the `done` cycle; a new op accepted in the next cycle completes 34 cycles after acceptance.
  - `rst` pulsed in cycle 20: all outputs go to 0 asynchronously, and no `done` follows.
